// File: rtl/v810_exc_seq.sv
// v810_exc_seq
// Exception, interrupt and RETI sequencer for the V810 core.
// Owns the system-register file's read/write port and the PSW/ECR update
// strobes. Each accepted request runs a fixed multi-cycle sequence and then
// hands the core a redirect target.
//
// Ports
//   CLK, RES, CE         clock, async active-high reset, global clock enable
//   EXC_REQ/CODE/PC      synchronous exception request (held until ACK)
//   INT_REQ/LEVEL/PC     maskable interrupt request
//   RETI_REQ             RETI instruction request
//   ACK                  request accepted (asserted in the accepting IDLE cycle)
//   BUSY                 sequence in progress
//   REDIR, REDIR_PC      fetch redirect strobe and target (target is held)
//   FATAL                NP-nested exception
//   PSW                  current PSW from the sysreg file
//   SR_RA, SR_RD         sysreg read port (read data is combinational)
//   SR_WA, SR_WD, SR_WE  sysreg write port
//   PSW_SET, PSW_RESET   PSW bit set/clear strobes
//   ECR_CC, ECR_SET_*    ECR cause-code update
module v810_exc_seq #(
  parameter bit FATAL_HALT = 1'b1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic        EXC_REQ,
  input  logic [15:0] EXC_CODE,
  input  logic [31:0] EXC_PC,
  input  logic        INT_REQ,
  input  logic [3:0]  INT_LEVEL,
  input  logic [31:0] INT_PC,
  input  logic        RETI_REQ,
  output logic        ACK,
  output logic        BUSY,
  output logic        REDIR,
  output logic [31:0] REDIR_PC,
  output logic        FATAL,
  input  logic [31:0] PSW,
  output logic [4:0]  SR_RA,
  input  logic [31:0] SR_RD,
  output logic [4:0]  SR_WA,
  output logic [31:0] SR_WD,
  output logic        SR_WE,
  output logic [31:0] PSW_SET,
  output logic [31:0] PSW_RESET,
  output logic [15:0] ECR_CC,
  output logic        ECR_SET_EICC,
  output logic        ECR_SET_FECC
);

  // System register addresses
  localparam logic [4:0] SR_EIPC  = 5'd0;
  localparam logic [4:0] SR_EIPSW = 5'd1;
  localparam logic [4:0] SR_FEPC  = 5'd2;
  localparam logic [4:0] SR_FEPSW = 5'd3;
  localparam logic [4:0] SR_PSW   = 5'd5;

  // PSW control bit positions
  localparam int B_ID = 12;
  localparam int B_AE = 13;
  localparam int B_EP = 14;
  localparam int B_NP = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_PC,
    S_SAVE_PSW,
    S_UPDATE,
    S_RETI_PC,
    S_RETI_PSW,
    S_DONE,
    S_FATAL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lat_code;
  logic [31:0] lat_pc;
  logic [3:0]  lat_level;
  logic        lat_int;
  logic        lat_dup;
  logic        redir_load;
  logic [31:0] redir_val;
  logic        int_ok;
  logic        take_exc;
  logic        take_int;
  logic        take_reti;
  logic [3:0]  level_inc;

  // Interrupts are only eligible when no exception handler is active and the
  // level is at least the current mask level. Priority is EXC > INT > RETI.
  assign int_ok    = INT_REQ & ~PSW[B_ID] & ~PSW[B_EP] & ~PSW[B_NP] &
                     (INT_LEVEL >= PSW[19:16]);
  assign take_exc  = EXC_REQ;
  assign take_int  = ~EXC_REQ & int_ok;
  assign take_reti = ~EXC_REQ & ~int_ok & RETI_REQ;

  // New interrupt mask after entry saturates at 15.
  assign level_inc = (lat_level == 4'hF) ? 4'hF : lat_level + 4'd1;

  assign BUSY  = (state != S_IDLE);
  assign REDIR = (state == S_DONE);

  // Next-state and per-state strobes. Every strobe defaults to zero so it
  // is only active in the one state that owns it.
  always_comb begin
    state_nxt    = state;
    ACK          = 1'b0;
    FATAL        = 1'b0;
    SR_RA        = 5'd0;
    SR_WA        = 5'd0;
    SR_WD        = 32'd0;
    SR_WE        = 1'b0;
    PSW_SET      = 32'd0;
    PSW_RESET    = 32'd0;
    ECR_CC       = 16'd0;
    ECR_SET_EICC = 1'b0;
    ECR_SET_FECC = 1'b0;
    redir_load   = 1'b0;
    redir_val    = 32'd0;
    case (state)
      S_IDLE: begin
        if (!RES) begin
          if (take_exc) begin
            ACK = 1'b1;
            if (PSW[B_NP]) begin
              if (FATAL_HALT) state_nxt = S_FATAL;
              else            FATAL     = 1'b1;
            end else begin
              state_nxt = S_SAVE_PC;
            end
          end else if (take_int) begin
            ACK       = 1'b1;
            state_nxt = S_SAVE_PC;
          end else if (take_reti) begin
            ACK       = 1'b1;
            state_nxt = S_RETI_PC;
          end
        end
      end
      S_SAVE_PC: begin
        SR_WE     = 1'b1;
        SR_WA     = lat_dup ? SR_FEPC : SR_EIPC;
        SR_WD     = lat_pc;
        state_nxt = S_SAVE_PSW;
      end
      S_SAVE_PSW: begin
        SR_WE     = 1'b1;
        SR_WA     = lat_dup ? SR_FEPSW : SR_EIPSW;
        SR_WD     = PSW;
        state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        ECR_CC           = lat_code;
        PSW_RESET[B_AE]  = 1'b1;
        PSW_SET[B_ID]    = 1'b1;
        redir_load       = 1'b1;
        if (lat_dup) begin
          ECR_SET_FECC   = 1'b1;
          PSW_SET[B_NP]  = 1'b1;
          redir_val      = 32'hFFFF_FFD0;
        end else begin
          ECR_SET_EICC   = 1'b1;
          PSW_SET[B_EP]  = 1'b1;
          redir_val      = {16'hFFFF, lat_code[15:4], 4'h0};
          if (lat_int) begin
            PSW_RESET[19:16] = 4'hF;
            PSW_SET[19:16]   = level_inc;
          end
        end
        state_nxt = S_DONE;
      end
      S_RETI_PC: begin
        SR_RA      = PSW[B_NP] ? SR_FEPC : SR_EIPC;
        redir_load = 1'b1;
        redir_val  = SR_RD;
        state_nxt  = S_RETI_PSW;
      end
      S_RETI_PSW: begin
        SR_RA     = PSW[B_NP] ? SR_FEPSW : SR_EIPSW;
        SR_WE     = 1'b1;
        SR_WA     = SR_PSW;
        SR_WD     = SR_RD;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_FATAL: begin
        FATAL = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus the request context captured at acceptance. An
  // interrupt is recorded with its synthesized cause code so the later
  // states treat both request kinds uniformly.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state     <= S_IDLE;
      lat_code  <= 16'd0;
      lat_pc    <= 32'd0;
      lat_level <= 4'd0;
      lat_int   <= 1'b0;
      lat_dup   <= 1'b0;
      REDIR_PC  <= 32'd0;
    end else if (CE) begin
      state <= state_nxt;
      if (state == S_IDLE && ACK) begin
        lat_int   <= take_int;
        lat_code  <= take_exc ? EXC_CODE : {8'hFE, INT_LEVEL, 4'h0};
        lat_pc    <= take_exc ? EXC_PC : INT_PC;
        lat_level <= INT_LEVEL;
        lat_dup   <= take_exc & PSW[B_EP];
      end
      if (redir_load) begin
        REDIR_PC <= redir_val;
      end
    end
  end

endmodule
